// File: rtl/bg_requester.sv
// rtl/bg_requester.sv - bankgroup burst requester with in-order response FIFO
module bg_requester #(
  parameter int A_W       = 10,
  parameter int LEN_W     = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_flush,
  input  logic             cmd_pattern,
  input  logic [1:0]       cmd_fifo_sel,
  input  logic [A_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             bg_en,
  output logic             bg_we,
  output logic             bg_re,
  output logic             bg_flush,
  output logic             bg_pattern,
  output logic [1:0]       bg_fifo_sel,
  output logic [A_W-1:0]   bg_addr,
  output logic [31:0]      bg_din,
  input  logic [32:0]      bg_dout_bus,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic             err_stray
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(RSP_DEPTH);

  typedef enum logic [2:0] {IDLE, FLUSH, WRITE, READ, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, beat_q;
  logic [A_W-1:0]   cur_addr_q;
  logic [CW-1:0]    outst_q, cnt_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [31:0]      mem [RSP_DEPTH];

  logic accept, wr_issue, rd_issue, flush_issue, done_d, last_beat, issue;
  logic rsp_valid, rsp_accept, stray, pop, push_ok, overflow;
  logic [SW-1:0] occupancy;

  assign last_beat = (beat_q == len_q - LEN_W'(1));
  assign occupancy = SW'(outst_q) + SW'(cnt_q);
  assign issue     = wr_issue | rd_issue;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    wr_issue    = 1'b0;
    rd_issue    = 1'b0;
    flush_issue = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_flush)            state_d = FLUSH;
          else if (cmd_len == '0)   done_d  = 1'b1;
          else if (cmd_write)       state_d = WRITE;
          else                      state_d = READ;
        end
      end
      FLUSH: begin
        flush_issue = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      WRITE: begin
        if (wdata_valid) begin
          wr_issue = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        // Never let in-flight reads exceed the space left in the response FIFO.
        if (occupancy < DEPTH_S) begin
          rd_issue = 1'b1;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done        <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      cur_addr_q  <= '0;
      bg_pattern  <= 1'b0;
      bg_fifo_sel <= '0;
      bg_en       <= 1'b0;
      bg_we       <= 1'b0;
      bg_re       <= 1'b0;
      bg_flush    <= 1'b0;
      bg_addr     <= '0;
      bg_din      <= '0;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      bg_en    <= issue;
      bg_we    <= wr_issue;
      bg_re    <= rd_issue;
      bg_flush <= flush_issue;
      if (accept) begin
        len_q       <= cmd_len;
        beat_q      <= '0;
        cur_addr_q  <= cmd_addr;
        bg_pattern  <= cmd_pattern;
        bg_fifo_sel <= cmd_fifo_sel;
      end else if (issue) begin
        beat_q <= beat_q + LEN_W'(1);
        if (!bg_pattern) cur_addr_q <= cur_addr_q + A_W'(1);
      end
      if (issue)    bg_addr <= cur_addr_q;
      if (wr_issue) bg_din  <= wdata;
    end
  end

  assign rsp_valid  = bg_dout_bus[32];
  assign rsp_accept = rsp_valid && (outst_q != '0);
  assign stray      = rsp_valid && (outst_q == '0);
  assign pop        = (cnt_q != '0) && rdata_ready;
  assign push_ok    = rsp_accept && ((cnt_q != DEPTH_C) || pop);
  assign overflow   = rsp_accept && (cnt_q == DEPTH_C) && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q      <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_stray    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case ({rd_issue, rsp_accept})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      err_stray    <= err_stray | stray;
      err_overflow <= err_overflow | overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bg_dout_bus[31:0];
  end

  assign rdata_valid = (cnt_q != '0);
  assign rdata       = rdata_valid ? mem[rd_ptr_q] : '0;
  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_bg_requester.sv
// tb/tb_bg_requester.sv - directed bench for bg_requester with 2-cycle bankgroup model
module tb_bg_requester;
  localparam int A_W = 10;
  localparam int LEN_W = 10;
  localparam int RSP_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 0, cmd_write = 0, cmd_flush = 0, cmd_pattern = 0;
  logic [1:0] cmd_fifo_sel = '0;
  logic [A_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic wdata_valid = 0, rdata_ready = 0;
  logic [31:0] wdata = '0;
  logic cmd_ready, wdata_ready, rdata_valid;
  logic [31:0] rdata, bg_din;
  logic bg_en, bg_we, bg_re, bg_flush, bg_pattern;
  logic [1:0] bg_fifo_sel;
  logic [A_W-1:0] bg_addr;
  logic [32:0] bg_dout_bus;
  logic busy, done, err_overflow, err_stray;

  logic [32:0] model_bus = '0, inject_bus = '0, stage1 = '0, stage2 = '0;
  assign bg_dout_bus = model_bus | inject_bus;

  int checks = 0, errors = 0;
  int rd_issued = 0, done_cnt = 0, rsp_cnt = 0;

  always #5 clk = ~clk;

  bg_requester #(.A_W(A_W), .LEN_W(LEN_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_flush(cmd_flush), .cmd_pattern(cmd_pattern), .cmd_fifo_sel(cmd_fifo_sel),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .bg_en(bg_en), .bg_we(bg_we), .bg_re(bg_re), .bg_flush(bg_flush),
    .bg_pattern(bg_pattern), .bg_fifo_sel(bg_fifo_sel), .bg_addr(bg_addr),
    .bg_din(bg_din), .bg_dout_bus(bg_dout_bus),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_stray(err_stray)
  );

  // Bankgroup model: a read seen in cycle k returns {1, 0xC0DE0000|addr} in cycle k+2.
  always @(negedge clk) begin
    if (bg_en && bg_re) rd_issued++;
    if (done) done_cnt++;
    if (bg_dout_bus[32]) rsp_cnt++;
    model_bus = stage2;
    stage2 = stage1;
    stage1 = (bg_en && bg_re) ? {1'b1, 32'hC0DE_0000 | {22'd0, bg_addr}} : 33'd0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic f, input logic p, input logic [1:0] fs,
                          input logic [A_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_write = w; cmd_flush = f; cmd_pattern = p; cmd_fifo_sel = fs;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [A_W-1:0] wa [3] = '{10'h3FE, 10'h3FF, 10'h000};
  logic [31:0]    wd [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

  initial begin
    int base, d0, r0, got, rsp_at_done;
    logic seen_done;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, r0, got, rsp_at_done;
    logic seen_done;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bg_en", bg_en, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_errs", {err_stray, err_overflow}, 0);
    rst_n = 1'b1;
    tick();

    // Random write wrapping past the top of the address space
    send_cmd(1, 0, 0, 0, 10'h3FE, 3);
    check("wr_wdata_ready", wdata_ready, 1);
    check("wr_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      wdata_valid = 1'b1;
      wdata = wd[i];
      tick();
      check("wr_ctl", {bg_en, bg_we, bg_re, bg_pattern}, 4'b1100);
      check("wr_addr", bg_addr, wa[i]);
      check("wr_din", bg_din, wd[i]);
      check("wr_done", done, (i == 2));
    end
    wdata_valid = 1'b0;
    tick();
    check("wr_after", {bg_en, done, busy}, 0);

    // Random read with stalled consumer: only RSP_DEPTH reads may be in flight
    base = rd_issued; d0 = done_cnt; r0 = rsp_cnt;
    send_cmd(0, 0, 0, 1, 10'h100, 6);
    repeat (20) tick();
    check("rd_stall_issued", rd_issued - base, 4);
    check("rd_stall_busy", busy, 1);
    check("rd_stall_head", rdata, 32'hC0DE_0100);
    rdata_ready = 1'b1;
    got = 0; seen_done = 1'b0; rsp_at_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (rdata_valid && got < 6) begin
        check("rd_word", rdata, 32'hC0DE_0100 + got);
        got++;
      end
      if (done && !seen_done) begin
        seen_done = 1'b1;
        rsp_at_done = rsp_cnt - r0;
      end
      if (got == 6 && seen_done) break;
      tick();
    end
    rdata_ready = 1'b0;
    check("rd_words", got, 6);
    check("rd_done_seen", seen_done, 1);
    check("rd_done_after_rsp", rsp_at_done, 6);
    check("rd_total_issued", rd_issued - base, 6);
    tick();
    check("rd_done_count", done_cnt - d0, 1);
    check("rd_idle", busy, 0);

    // Fill FIFO with two words, then flush must leave them in place
    send_cmd(0, 0, 0, 0, 10'h200, 2);
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin seen_done = 1'b1; break; end
      tick();
    end
    check("fill_done", seen_done, 1);
    tick();
    send_cmd(0, 1, 0, 0, 10'h000, 5);
    check("fl_busy", {busy, bg_flush}, 2'b10);
    tick();
    check("fl_pulse", {bg_flush, bg_en, done}, 3'b101);
    tick();
    check("fl_after", {bg_flush, done, busy}, 0);
    check("fl_keep0", {rdata_valid, rdata}, {1'b1, 32'hC0DE_0200});
    rdata_ready = 1'b1;
    tick();
    check("fl_keep1", {rdata_valid, rdata}, {1'b1, 32'hC0DE_0201});
    tick();
    rdata_ready = 1'b0;
    check("fl_empty", rdata_valid, 0);

    // FIFO-mode write holds address and select
    send_cmd(1, 0, 1, 2, 10'h010, 2);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata = 32'h5151_0000 + i;
      tick();
      check("ff_ctl", {bg_en, bg_we, bg_pattern, bg_fifo_sel}, 5'b11110);
      check("ff_addr", bg_addr, 10'h010);
      check("ff_done", done, (i == 1));
    end
    wdata_valid = 1'b0;
    tick();
    check("ff_hold", {bg_en, bg_pattern, bg_fifo_sel}, 4'b0110);

    // Zero-length read completes immediately without issuing
    base = rd_issued;
    send_cmd(0, 0, 0, 0, 10'h050, 0);
    check("z_pulse", {done, cmd_ready, bg_en, busy}, 4'b1100);
    tick();
    check("z_after", {done, cmd_ready, bg_en}, 3'b010);
    check("z_no_read", rd_issued - base, 0);

    // Stray response while idle
    inject_bus = 33'h1_DEADBEEF;
    tick();
    inject_bus = '0;
    check("stray_flag", err_stray, 1);
    check("stray_no_data", rdata_valid, 0);
    tick();
    check("stray_sticky", {err_stray, err_overflow}, 2'b10);

    // Reset in the middle of a read burst
    d0 = done_cnt;
    send_cmd(0, 0, 0, 0, 10'h300, 6);
    repeat (3) tick();
    check("mr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_ctl", {bg_en, bg_we, bg_re, bg_flush, bg_pattern, bg_fifo_sel}, 0);
    check("mr_addr", bg_addr, 0);
    check("mr_din", bg_din, 0);
    check("mr_rdata", {rdata_valid, rdata}, 0);
    check("mr_status", {busy, done, err_stray, err_overflow, wdata_ready}, 0);
    check("mr_cmd_ready", cmd_ready, 1);
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_clean", {busy, err_stray, rdata_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
